// File: rtl/spi_cfg_shadow.sv
// -----------------------------------------------------------------------------
// spi_cfg_shadow
//
// Double-buffered configuration register file for an SPI core. Writes go into
// a shadow bank and mark the field dirty. On a commit request the block waits
// until the SPI core reports a safe point. It then copies every dirty field
// into the active bank in a single cycle, so software never sees a partly
// applied configuration.
//
// Parameters
//   N_FIELDS   number of configuration fields (2..64)
//   FIELD_W    width of each field in bits (1..32)
//   ADDR_W     field address width, must equal $clog2(N_FIELDS)
//   DEFAULTS   packed reset value of each field; field i is [i*FIELD_W +: FIELD_W]
//   FIELD_MIN  packed per-field inclusive lower bound (range-check build only)
//   FIELD_MAX  packed per-field inclusive upper bound (range-check build only)
//
// Ports
//   spi_clk     in   clock, all logic on the rising edge
//   spi_resetn  in   asynchronous active-low reset
//   wr_valid    in   staging write request
//   wr_ready    out  staging write accepted (high in IDLE)
//   wr_addr     in   field index of the staged write
//   wr_data     in   value of the staged write
//   commit_req  in   apply all staged fields atomically
//   safe        in   SPI core is between transactions
//   err_clr     in   clear wr_err
//   cfg_out     out  active configuration, same packing as DEFAULTS
//   cfg_update  out  one-cycle pulse on the first cycle cfg_out holds new values
//   pending     out  some staged write is not yet committed
//   wr_err      out  sticky flag, set by rejected writes
//
// Build option
//   SPI_CFG_SHADOW_RANGE_CHECK_EN: when defined, a write to a valid address
//   with data outside [FIELD_MIN, FIELD_MAX] is rejected. When undefined, the
//   bounds are ignored and no comparators are built.
// -----------------------------------------------------------------------------
module spi_cfg_shadow #(
   parameter int                          N_FIELDS  = 8,
   parameter int                          FIELD_W   = 32,
   parameter int                          ADDR_W    = 3,
   parameter logic [N_FIELDS*FIELD_W-1:0] DEFAULTS  = '0,
   parameter logic [N_FIELDS*FIELD_W-1:0] FIELD_MIN = '0,
   parameter logic [N_FIELDS*FIELD_W-1:0] FIELD_MAX = '1
) (
   input  logic                          spi_clk,
   input  logic                          spi_resetn,
   input  logic                          wr_valid,
   output logic                          wr_ready,
   input  logic [ADDR_W-1:0]             wr_addr,
   input  logic [FIELD_W-1:0]            wr_data,
   input  logic                          commit_req,
   input  logic                          safe,
   input  logic                          err_clr,
   output logic [N_FIELDS*FIELD_W-1:0]   cfg_out,
   output logic                          cfg_update,
   output logic                          pending,
   output logic                          wr_err
);

   localparam logic [0:0] ST_IDLE      = 1'b0;
   localparam logic [0:0] ST_WAIT_SAFE = 1'b1;

   // The field count widened by one bit, so the address compare stays correct
   // when N_FIELDS is an exact power of two.
   localparam logic [ADDR_W:0] LP_N_FIELDS = (ADDR_W + 1)'(N_FIELDS);

   // Elaboration-time parameter sanity checks. These generate no logic.
   generate
      if (ADDR_W != $clog2(N_FIELDS)) begin : g_bad_addr_w
         $error("spi_cfg_shadow: ADDR_W must equal $clog2(N_FIELDS)");
      end
      for (genvar g = 0; g < N_FIELDS; g++) begin : g_bound_chk
         if (FIELD_MIN[g*FIELD_W +: FIELD_W] > FIELD_MAX[g*FIELD_W +: FIELD_W]) begin : g_bad_bounds
            $error("spi_cfg_shadow: FIELD_MIN exceeds FIELD_MAX for a field");
         end
      end
   endgenerate

   logic [0:0]          r_state;
   logic [FIELD_W-1:0]  r_shadow [N_FIELDS];
   logic [FIELD_W-1:0]  r_active [N_FIELDS];
   logic [N_FIELDS-1:0] r_dirty;
   logic                r_cfg_update;
   logic                r_wr_err;

   logic w_wr_fire;
   logic w_addr_ok;
   logic w_range_ok;
   logic w_stage;
   logic w_reject;
   logic w_commit;

   assign wr_ready  = (r_state == ST_IDLE);
   assign w_wr_fire = wr_valid && wr_ready;
   assign w_addr_ok = ({1'b0, wr_addr} < LP_N_FIELDS);

`ifdef SPI_CFG_SHADOW_RANGE_CHECK_EN
   // NOTE: every signal written in always_comb gets a default value first.
   // Otherwise a path that leaves it unassigned infers a latch.
   always_comb begin
      w_range_ok = 1'b1;
      for (int i = 0; i < N_FIELDS; i++) begin
         if (wr_addr == ADDR_W'(i)) begin
            w_range_ok = (wr_data >= FIELD_MIN[i*FIELD_W +: FIELD_W]) &&
                         (wr_data <= FIELD_MAX[i*FIELD_W +: FIELD_W]);
         end
      end
   end
`else
   assign w_range_ok = 1'b1;
`endif

   // A rejected write still completes the handshake. It only sets wr_err.
   assign w_stage  = w_wr_fire &&  (w_addr_ok && w_range_ok);
   assign w_reject = w_wr_fire && !(w_addr_ok && w_range_ok);
   assign w_commit = (r_state == ST_WAIT_SAFE) && safe;

   // NOTE: both banks are reset. DEFAULTS is the functional power-up
   // configuration, so these are ordinary registers with reset and not RAM.
   // NOTE: sequential state uses non-blocking assignments only. Every
   // register then samples values from before the edge, whatever the
   // statement order.
   always_ff @(posedge spi_clk or negedge spi_resetn) begin
      if (!spi_resetn) begin
         r_state      <= ST_IDLE;
         r_dirty      <= '0;
         r_cfg_update <= 1'b0;
         r_wr_err     <= 1'b0;
         for (int i = 0; i < N_FIELDS; i++) begin
            r_shadow[i] <= DEFAULTS[i*FIELD_W +: FIELD_W];
            r_active[i] <= DEFAULTS[i*FIELD_W +: FIELD_W];
         end
      end else begin
         r_cfg_update <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               // A write accepted in the same cycle as commit_req is already
               // in the shadow bank when WAIT_SAFE copies it.
               for (int i = 0; i < N_FIELDS; i++) begin
                  if (w_stage && (wr_addr == ADDR_W'(i))) begin
                     r_shadow[i] <= wr_data;
                     r_dirty[i]  <= 1'b1;
                  end
               end
               if (commit_req) begin
                  r_state <= ST_WAIT_SAFE;
               end
            end

            ST_WAIT_SAFE: begin
               // commit_req is ignored here. The commit already in flight
               // covers everything staged.
               if (w_commit) begin
                  for (int i = 0; i < N_FIELDS; i++) begin
                     if (r_dirty[i]) begin
                        r_active[i] <= r_shadow[i];
                     end
                  end
                  r_dirty      <= '0;
                  r_cfg_update <= |r_dirty;
                  r_state      <= ST_IDLE;
               end
            end

            default: r_state <= ST_IDLE;
         endcase

         // A rejection in the same cycle has priority over the clear.
         if (w_reject) begin
            r_wr_err <= 1'b1;
         end else if (err_clr) begin
            r_wr_err <= 1'b0;
         end
      end
   end

   always_comb begin
      cfg_out = '0;
      for (int i = 0; i < N_FIELDS; i++) begin
         cfg_out[i*FIELD_W +: FIELD_W] = r_active[i];
      end
   end

   assign cfg_update = r_cfg_update;
   assign pending    = |r_dirty;
   assign wr_err     = r_wr_err;

endmodule

// File: tb/tb_spi_cfg_shadow.sv
// -----------------------------------------------------------------------------
// tb_spi_cfg_shadow
//
// Testbench for spi_cfg_shadow with 5 fields of 32 bits. A table of
// single-cycle vectors covers staging, commit timing, address rejection and
// wr_err behaviour. Hand-written sequences cover a long safe=0 stall with a
// write held during the stall, and a reset applied in WAIT_SAFE.
// Vector 9 expects different results depending on
// SPI_CFG_SHADOW_RANGE_CHECK_EN.
// -----------------------------------------------------------------------------
module tb_spi_cfg_shadow;

   localparam int NF = 5;
   localparam int FW = 32;
   localparam int AW = 3;
   localparam int CW = NF * FW;

   localparam logic [CW-1:0] P_DEFAULTS = {32'h44, 32'h33, 32'h1000, 32'h7, 32'h11};
   localparam logic [CW-1:0] P_MIN      = '0;
   localparam logic [CW-1:0] P_MAX      = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                           32'd31, 32'hFFFF_FFFF};

   logic          spi_clk;
   logic          spi_resetn;
   logic          wr_valid;
   logic          wr_ready;
   logic [AW-1:0] wr_addr;
   logic [FW-1:0] wr_data;
   logic          commit_req;
   logic          safe;
   logic          err_clr;
   logic [CW-1:0] cfg_out;
   logic          cfg_update;
   logic          pending;
   logic          wr_err;

   int n_tests;
   int n_fail;

   spi_cfg_shadow #(
      .N_FIELDS  (NF),
      .FIELD_W   (FW),
      .ADDR_W    (AW),
      .DEFAULTS  (P_DEFAULTS),
      .FIELD_MIN (P_MIN),
      .FIELD_MAX (P_MAX)
   ) dut (
      .spi_clk    (spi_clk),
      .spi_resetn (spi_resetn),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .commit_req (commit_req),
      .safe       (safe),
      .err_clr    (err_clr),
      .cfg_out    (cfg_out),
      .cfg_update (cfg_update),
      .pending    (pending),
      .wr_err     (wr_err)
   );

   initial spi_clk = 1'b0;
   always #5 spi_clk = ~spi_clk;

   typedef struct {
      logic          wr_valid;
      logic [AW-1:0] wr_addr;
      logic [FW-1:0] wr_data;
      logic          commit_req;
      logic          safe;
      logic          err_clr;
      logic          exp_ready;
      logic          exp_pending;
      logic          exp_err;
      logic          exp_update;
      logic [CW-1:0] exp_cfg;
   } vec_t;

   localparam int NV = 23;
   vec_t vecs [NV];

   function automatic logic [CW-1:0] pack5(input logic [FW-1:0] f0, input logic [FW-1:0] f1,
                                           input logic [FW-1:0] f2, input logic [FW-1:0] f3,
                                           input logic [FW-1:0] f4);
      return {f4, f3, f2, f1, f0};
   endfunction

   function automatic vec_t mk(input logic v, input logic [AW-1:0] a, input logic [FW-1:0] d,
                               input logic c, input logic s, input logic clr,
                               input logic er, input logic ep, input logic ee, input logic eu,
                               input logic [CW-1:0] ecfg);
      vec_t r;
      r.wr_valid    = v;
      r.wr_addr     = a;
      r.wr_data     = d;
      r.commit_req  = c;
      r.safe        = s;
      r.err_clr     = clr;
      r.exp_ready   = er;
      r.exp_pending = ep;
      r.exp_err     = ee;
      r.exp_update  = eu;
      r.exp_cfg     = ecfg;
      return r;
   endfunction

   task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [AW-1:0] a, input logic [FW-1:0] d,
                        input logic c, input logic s, input logic clr);
      wr_valid   = v;
      wr_addr    = a;
      wr_data    = d;
      commit_req = c;
      safe       = s;
      err_clr    = clr;
   endtask

   // Let one rising edge pass, then return on the falling edge to sample.
   task automatic step();
      @(posedge spi_clk);
      @(negedge spi_clk);
   endtask

   logic [CW-1:0] c_def, c1, c2, c3, c4, c5;

   initial begin
      n_tests = 0;
      n_fail  = 0;

      c_def = P_DEFAULTS;
      c1    = pack5(32'h5,  32'd20, 32'h1000, 32'hABCD, 32'h44);
      c1[1*FW +: FW] = 32'h7;
      c1[0*FW +: FW] = 32'h11;
      c2    = pack5(32'h5,  32'd20, 32'h1000, 32'hABCD, 32'h44);
      c3    = pack5(32'h5,  32'd20, 32'hBBBB, 32'hABCD, 32'h44);
      c4    = pack5(32'h5,  32'd20, 32'hBBBB, 32'hABCD, 32'h55);
      c5    = pack5(32'h5,  32'd20, 32'hBBBB, 32'h77,   32'h55);

      //            v  a  data         c  s  clr  rdy pnd err upd cfg
      vecs[0]  = mk(1, 3, 32'hABCD,    0, 0, 0,   1,  1,  0,  0,  c_def);
      vecs[1]  = mk(0, 0, 32'h0,       1, 1, 0,   0,  1,  0,  0,  c_def);
      vecs[2]  = mk(0, 0, 32'h0,       0, 1, 0,   1,  0,  0,  1,  c1);
      vecs[3]  = mk(0, 0, 32'h0,       0, 1, 0,   1,  0,  0,  0,  c1);
      vecs[4]  = mk(1, 6, 32'h99,      0, 0, 0,   1,  0,  1,  0,  c1);
      vecs[5]  = mk(1, 5, 32'h99,      0, 0, 0,   1,  0,  1,  0,  c1);
      vecs[6]  = mk(0, 0, 32'h0,       0, 0, 1,   1,  0,  0,  0,  c1);
      vecs[7]  = mk(1, 7, 32'h0,       0, 0, 1,   1,  0,  1,  0,  c1);
      vecs[8]  = mk(0, 0, 32'h0,       0, 0, 1,   1,  0,  0,  0,  c1);
`ifdef SPI_CFG_SHADOW_RANGE_CHECK_EN
      vecs[9]  = mk(1, 1, 32'd40,      0, 0, 0,   1,  0,  1,  0,  c1);
`else
      vecs[9]  = mk(1, 1, 32'd40,      0, 0, 0,   1,  1,  0,  0,  c1);
`endif
      vecs[10] = mk(1, 1, 32'd20,      0, 0, 1,   1,  1,  0,  0,  c1);
      vecs[11] = mk(1, 0, 32'h5,       1, 0, 0,   0,  1,  0,  0,  c1);
      vecs[12] = mk(0, 0, 32'h0,       0, 0, 0,   0,  1,  0,  0,  c1);
      vecs[13] = mk(0, 0, 32'h0,       1, 0, 0,   0,  1,  0,  0,  c1);
      vecs[14] = mk(0, 0, 32'h0,       0, 1, 0,   1,  0,  0,  1,  c2);
      vecs[15] = mk(0, 0, 32'h0,       0, 0, 0,   1,  0,  0,  0,  c2);
      vecs[16] = mk(1, 2, 32'hAAAA,    0, 0, 0,   1,  1,  0,  0,  c2);
      vecs[17] = mk(1, 2, 32'hBBBB,    0, 0, 0,   1,  1,  0,  0,  c2);
      vecs[18] = mk(0, 0, 32'h0,       1, 0, 0,   0,  1,  0,  0,  c2);
      vecs[19] = mk(0, 0, 32'h0,       0, 1, 0,   1,  0,  0,  1,  c3);
      vecs[20] = mk(0, 0, 32'h0,       1, 0, 0,   0,  0,  0,  0,  c3);
      vecs[21] = mk(0, 0, 32'h0,       0, 1, 0,   1,  0,  0,  0,  c3);
      vecs[22] = mk(0, 0, 32'h0,       0, 0, 0,   1,  0,  0,  0,  c3);

      // Reset
      spi_resetn = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      repeat (2) @(negedge spi_clk);
      spi_resetn = 1'b1;
      check("reset cfg_out",    cfg_out,    c_def);
      check("reset pending",    CW'(pending),    CW'(1'b0));
      check("reset wr_ready",   CW'(wr_ready),   CW'(1'b1));
      check("reset wr_err",     CW'(wr_err),     CW'(1'b0));
      check("reset cfg_update", CW'(cfg_update), CW'(1'b0));

      // Table-driven single-cycle vectors
      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].wr_valid, vecs[i].wr_addr, vecs[i].wr_data,
               vecs[i].commit_req, vecs[i].safe, vecs[i].err_clr);
         step();
         check($sformatf("v%0d wr_ready", i),   CW'(wr_ready),   CW'(vecs[i].exp_ready));
         check($sformatf("v%0d pending", i),    CW'(pending),    CW'(vecs[i].exp_pending));
         check($sformatf("v%0d wr_err", i),     CW'(wr_err),     CW'(vecs[i].exp_err));
         check($sformatf("v%0d cfg_update", i), CW'(cfg_update), CW'(vecs[i].exp_update));
         check($sformatf("v%0d cfg_out", i),    cfg_out,         vecs[i].exp_cfg);
      end

      // Long stall on safe=0, with a write held during the stall
      drive(1, 4, 32'h55, 0, 0, 0);
      step();
      check("stall stage pending", CW'(pending), CW'(1'b1));
      drive(0, 0, 0, 1, 0, 0);
      step();
      check("stall enter ready", CW'(wr_ready), CW'(1'b0));
      drive(1, 3, 32'h77, 0, 0, 0);
      for (int k = 0; k < 10; k++) begin
         step();
         check($sformatf("stall%0d wr_ready", k),   CW'(wr_ready),   CW'(1'b0));
         check($sformatf("stall%0d cfg_out", k),    cfg_out,         c3);
         check($sformatf("stall%0d cfg_update", k), CW'(cfg_update), CW'(1'b0));
      end
      drive(1, 3, 32'h77, 0, 1, 0);
      step();
      check("stall commit ready",   CW'(wr_ready),   CW'(1'b1));
      check("stall commit update",  CW'(cfg_update), CW'(1'b1));
      check("stall commit pending", CW'(pending),    CW'(1'b0));
      check("stall commit cfg",     cfg_out,         c4);
      step();
      check("held write pending", CW'(pending),    CW'(1'b1));
      check("held write update",  CW'(cfg_update), CW'(1'b0));
      check("held write cfg",     cfg_out,         c4);
      drive(0, 0, 0, 1, 1, 0);
      step();
      check("held commit ready", CW'(wr_ready), CW'(1'b0));
      drive(0, 0, 0, 0, 1, 0);
      step();
      check("held commit cfg",    cfg_out,         c5);
      check("held commit update", CW'(cfg_update), CW'(1'b1));

      // Reset asserted while in WAIT_SAFE with field 4 dirty
      drive(1, 6, 32'h0, 0, 0, 0);
      step();
      check("pre-reset wr_err", CW'(wr_err), CW'(1'b1));
      drive(1, 4, 32'h66, 0, 0, 0);
      step();
      check("pre-reset pending", CW'(pending), CW'(1'b1));
      drive(0, 0, 0, 1, 0, 0);
      step();
      check("pre-reset ready", CW'(wr_ready), CW'(1'b0));
      #2;
      spi_resetn = 1'b0;
      #1;
      check("in-reset cfg_out",    cfg_out,         c_def);
      check("in-reset pending",    CW'(pending),    CW'(1'b0));
      check("in-reset wr_ready",   CW'(wr_ready),   CW'(1'b1));
      check("in-reset wr_err",     CW'(wr_err),     CW'(1'b0));
      check("in-reset cfg_update", CW'(cfg_update), CW'(1'b0));
      drive(0, 0, 0, 0, 1, 0);
      @(negedge spi_clk);
      spi_resetn = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         check($sformatf("post-reset%0d cfg_update", k), CW'(cfg_update), CW'(1'b0));
         check($sformatf("post-reset%0d cfg_out", k),    cfg_out,         c_def);
         check($sformatf("post-reset%0d wr_ready", k),   CW'(wr_ready),   CW'(1'b1));
         check($sformatf("post-reset%0d pending", k),    CW'(pending),    CW'(1'b0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
